// File: rtl/tqvp_bus_sequencer.sv
// Bus sequencer between the TinyQV core data port and up to three peripheral slots plus a local
// register slot (slot 3). Registers every request, handles read waits with a timeout, merges IRQs.
module tqvp_bus_sequencer #(
    parameter int NUM_PERIPH = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                address,
    input  logic [31:0]               data_in,
    input  logic [1:0]                data_write_n,
    input  logic [1:0]                data_read_n,
    output logic [31:0]               data_out,
    output logic                      data_ready,
    output logic [5:0]                p_address,
    output logic [31:0]               p_data_in,
    output logic [2*NUM_PERIPH-1:0]   p_data_write_n,
    output logic [2*NUM_PERIPH-1:0]   p_data_read_n,
    input  logic [32*NUM_PERIPH-1:0]  p_data_out,
    input  logic [NUM_PERIPH-1:0]     p_data_ready,
    input  logic [NUM_PERIPH-1:0]     p_interrupt,
    output logic                      user_interrupt
);

    typedef enum logic [1:0] {StIdle, StWrite, StReadWait, StDone} state_t;

    localparam logic [2:0] NumSlots   = 3'(NUM_PERIPH);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    localparam logic [1:0] LocalSlot  = 2'd3;

    state_t                  r_state, w_state_d;
    logic [1:0]              r_slot, w_slot_d;
    logic [1:0]              r_size, w_size_d;
    logic [5:0]              r_addr, w_addr_d;
    logic [31:0]             r_wdata, w_wdata_d;
    logic [31:0]             r_rdata, w_rdata_d;
    logic [7:0]              r_cnt, w_cnt_d;
    logic                    r_err, w_err_d;
    logic [1:0]              r_err_slot, w_err_slot_d;
    logic [NUM_PERIPH-1:0]   r_mask, w_mask_d;
    logic [2*NUM_PERIPH-1:0] r_wr_n, w_wr_n_d;
    logic [2*NUM_PERIPH-1:0] r_rd_n, w_rd_n_d;
    logic                    r_ready;
    logic                    r_irq;

    logic                    w_sel_ready;
    logic [31:0]             w_sel_data;
    logic [31:0]             w_local_rdata;
    logic [3:0]              w_irq_raw;

    assign w_irq_raw = 4'(p_interrupt);

    // Local register read value for the offset currently on the core bus
    always_comb begin
        w_local_rdata = '0;
        case (address[5:0])
            6'h00:   w_local_rdata = {24'b0, w_irq_raw, 1'b0, r_err_slot, r_err};
            6'h04:   w_local_rdata = 32'(r_mask);
            default: w_local_rdata = '0;
        endcase
    end

    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (r_slot == 2'(i)) begin
                w_sel_ready = p_data_ready[i];
                w_sel_data  = p_data_out[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_slot_d     = r_slot;
        w_size_d     = r_size;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_rdata_d    = r_rdata;
        w_cnt_d      = r_cnt;
        w_err_d      = r_err;
        w_err_slot_d = r_err_slot;
        w_mask_d     = r_mask;
        case (r_state)
            StIdle: begin
                if (data_write_n != 2'b11) begin
                    w_slot_d  = address[7:6];
                    w_addr_d  = address[5:0];
                    w_wdata_d = data_in;
                    w_size_d  = data_write_n;
                    w_state_d = StWrite;
                end else if (data_read_n != 2'b11) begin
                    w_slot_d = address[7:6];
                    w_addr_d = address[5:0];
                    w_size_d = data_read_n;
                    if ({1'b0, address[7:6]} < NumSlots) begin
                        w_cnt_d   = '0;
                        w_state_d = StReadWait;
                    end else begin
                        w_rdata_d = (address[7:6] == LocalSlot) ? w_local_rdata : '0;
                        w_state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (r_slot == LocalSlot) begin
                    // Clearing err also clears the slot it recorded
                    if (r_addr == 6'h00 && r_wdata[0]) begin
                        w_err_d      = 1'b0;
                        w_err_slot_d = 2'd0;
                    end
                    if (r_addr == 6'h04) w_mask_d = r_wdata[NUM_PERIPH-1:0];
                end
                w_state_d = StIdle;
            end
            StReadWait: begin
                w_cnt_d = r_cnt + 8'd1;
                if (w_sel_ready) begin
                    w_rdata_d = w_sel_data;
                    w_state_d = StDone;
                end else if (w_cnt_d == TimeoutCnt) begin
                    w_rdata_d    = 32'hFFFF_FFFF;
                    w_err_d      = 1'b1;
                    w_err_slot_d = r_slot;
                    w_state_d    = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they line up with WRITE / READ_WAIT
    always_comb begin
        w_wr_n_d = '1;
        w_rd_n_d = '1;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (w_slot_d == 2'(i)) begin
                if (w_state_d == StWrite)    w_wr_n_d[2*i +: 2] = w_size_d;
                if (w_state_d == StReadWait) w_rd_n_d[2*i +: 2] = w_size_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_slot     <= '0;
            r_size     <= 2'b11;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_slot <= '0;
            r_mask     <= '0;
            r_wr_n     <= '1;
            r_rd_n     <= '1;
            r_ready    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_slot     <= w_slot_d;
            r_size     <= w_size_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_rdata    <= w_rdata_d;
            r_cnt      <= w_cnt_d;
            r_err      <= w_err_d;
            r_err_slot <= w_err_slot_d;
            r_mask     <= w_mask_d;
            r_wr_n     <= w_wr_n_d;
            r_rd_n     <= w_rd_n_d;
            r_ready    <= (w_state_d == StDone);
            r_irq      <= |(p_interrupt & r_mask);
        end
    end

    assign data_out       = r_rdata;
    assign data_ready     = r_ready;
    assign p_address      = r_addr;
    assign p_data_in      = r_wdata;
    assign p_data_write_n = r_wr_n;
    assign p_data_read_n  = r_rd_n;
    assign user_interrupt = r_irq;

endmodule

// File: tb/tb_tqvp_bus_sequencer.sv
// Directed bench for tqvp_bus_sequencer: default instance (3 slots) plus a 2-slot instance for
// the unmapped-slot case.
module tb_tqvp_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n, data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic [5:0]  p_address;
    logic [31:0] p_data_in;
    logic [5:0]  p_data_write_n, p_data_read_n;
    logic [95:0] p_data_out;
    logic [2:0]  p_data_ready, p_interrupt;
    logic        user_interrupt;

    logic [7:0]  b_address;
    logic [1:0]  b_data_write_n, b_data_read_n;
    logic [31:0] b_data_out;
    logic        b_data_ready;
    logic [5:0]  b_p_address;
    logic [31:0] b_p_data_in;
    logic [3:0]  b_p_data_write_n, b_p_data_read_n;
    logic [1:0]  b_p_interrupt;
    logic        b_user_interrupt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tqvp_bus_sequencer u_dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .p_address(p_address), .p_data_in(p_data_in),
        .p_data_write_n(p_data_write_n), .p_data_read_n(p_data_read_n),
        .p_data_out(p_data_out), .p_data_ready(p_data_ready),
        .p_interrupt(p_interrupt), .user_interrupt(user_interrupt)
    );

    tqvp_bus_sequencer #(.NUM_PERIPH(2), .TIMEOUT(15)) u_dut2 (
        .clk(clk), .rst(rst), .address(b_address), .data_in(32'h0000_0000),
        .data_write_n(b_data_write_n), .data_read_n(b_data_read_n),
        .data_out(b_data_out), .data_ready(b_data_ready),
        .p_address(b_p_address), .p_data_in(b_p_data_in),
        .p_data_write_n(b_p_data_write_n), .p_data_read_n(b_p_data_read_n),
        .p_data_out(64'h1111_1111_2222_2222), .p_data_ready(2'b00),
        .p_interrupt(b_p_interrupt), .user_interrupt(b_user_interrupt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic local_read(input logic [5:0] off, output logic rdy, output logic [31:0] d);
        address     = {2'd3, off};
        data_read_n = 2'b10;
        step();
        rdy         = data_ready;
        d           = data_out;
        data_read_n = 2'b11;
        step();
    endtask

    task automatic local_write(input logic [5:0] off, input logic [31:0] d, input logic [1:0] sz);
        address      = {2'd3, off};
        data_in      = d;
        data_write_n = sz;
        step();
        data_write_n = 2'b11;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        address = 8'hFF; data_in = 32'hFFFF_FFFF; data_read_n = 2'b10;
        step(); step();
        rst = 1'b0; address = 8'h00; data_in = 32'h0; data_read_n = 2'b11;
        checks++;
        if (data_ready !== 1'b0 || data_out !== 32'h0) begin
            errors++; $display("FAIL reset_data got rdy=%b out=%h want rdy=0 out=0", data_ready, data_out);
        end
        checks++;
        if (p_data_write_n !== 6'h3F || p_data_read_n !== 6'h3F) begin
            errors++; $display("FAIL reset_strobes got wr=%b rd=%b want all 1", p_data_write_n, p_data_read_n);
        end
        checks++;
        if (p_address !== 6'h0 || p_data_in !== 32'h0 || user_interrupt !== 1'b0) begin
            errors++; $display("FAIL reset_regs got addr=%h din=%h irq=%b want 0", p_address, p_data_in, user_interrupt);
        end
    endtask

    task automatic test_zero_wait_read();
        p_data_ready = 3'b001; p_data_out[31:0] = 32'h1234_5678;
        address = {2'd0, 6'h10}; data_read_n = 2'b10;
        step();
        checks++;
        if (p_data_read_n !== 6'b111110 || data_ready !== 1'b0) begin
            errors++; $display("FAIL zw_strobe got rd=%b rdy=%b want 111110 0", p_data_read_n, data_ready);
        end
        step();
        checks++;
        if (data_ready !== 1'b1 || data_out !== 32'h1234_5678) begin
            errors++; $display("FAIL zw_data got rdy=%b out=%h want 1 12345678", data_ready, data_out);
        end
        checks++;
        if (p_data_read_n !== 6'h3F) begin
            errors++; $display("FAIL zw_strobe_off got rd=%b want 111111", p_data_read_n);
        end
        data_read_n = 2'b11; p_data_ready = 3'b000;
        step();
        checks++;
        if (data_ready !== 1'b0 || data_out !== 32'h1234_5678) begin
            errors++; $display("FAIL zw_pulse got rdy=%b out=%h want 0 12345678", data_ready, data_out);
        end
    endtask

    task automatic test_wait_read();
        address = {2'd1, 6'h04}; data_read_n = 2'b01;
        step();
        checks++;
        if (p_data_read_n !== 6'b110111 || p_address !== 6'h04) begin
            errors++; $display("FAIL ws_wait1 got rd=%b addr=%h want 110111 04", p_data_read_n, p_address);
        end
        step();
        checks++;
        if (data_ready !== 1'b0 || p_data_read_n !== 6'b110111) begin
            errors++; $display("FAIL ws_wait2 got rdy=%b rd=%b want 0 110111", data_ready, p_data_read_n);
        end
        step();
        p_data_ready = 3'b010; p_data_out[63:32] = 32'hA5A5_0001;
        checks++;
        if (data_ready !== 1'b0 || p_address !== 6'h04 || p_data_write_n !== 6'h3F) begin
            errors++; $display("FAIL ws_wait3 got rdy=%b addr=%h wr=%b want 0 04 111111", data_ready, p_address, p_data_write_n);
        end
        step();
        checks++;
        if (data_ready !== 1'b1 || data_out !== 32'hA5A5_0001 || p_data_read_n !== 6'h3F) begin
            errors++; $display("FAIL ws_done got rdy=%b out=%h rd=%b want 1 a5a50001 111111", data_ready, data_out, p_data_read_n);
        end
        data_read_n = 2'b11; p_data_ready = 3'b000;
        step();
    endtask

    task automatic test_timeout();
        logic        early = 1'b0;
        logic        rdy;
        logic [31:0] d;
        address = {2'd2, 6'h00}; data_read_n = 2'b10;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (data_ready) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL to_early got early_ready=1 want 0");
        end
        step();
        checks++;
        if (data_ready !== 1'b1 || data_out !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL to_data got rdy=%b out=%h want 1 ffffffff", data_ready, data_out);
        end
        data_read_n = 2'b11;
        step();
        local_read(6'h00, rdy, d);
        checks++;
        if (rdy !== 1'b1 || d !== 32'h05) begin
            errors++; $display("FAIL to_status got rdy=%b val=%h want 1 00000005", rdy, d);
        end
        local_write(6'h00, 32'h01, 2'b00);
        local_read(6'h00, rdy, d);
        checks++;
        if (d !== 32'h00) begin
            errors++; $display("FAIL to_clear got %h want 00000000", d);
        end
    endtask

    task automatic test_writes_irq();
        logic        rdy;
        logic [31:0] d;
        address = {2'd0, 6'h08}; data_in = 32'hDEAD_BE3C; data_write_n = 2'b00;
        step();
        data_write_n = 2'b11;
        checks++;
        if (p_data_write_n !== 6'b111100 || p_data_in[7:0] !== 8'h3C || p_address !== 6'h08) begin
            errors++; $display("FAIL wr_strobe got wr=%b din=%h addr=%h want 111100 3c 08", p_data_write_n, p_data_in[7:0], p_address);
        end
        step();
        checks++;
        if (p_data_write_n !== 6'h3F || p_data_in !== 32'hDEAD_BE3C || data_ready !== 1'b0) begin
            errors++; $display("FAIL wr_after got wr=%b din=%h rdy=%b want 111111 deadbe3c 0", p_data_write_n, p_data_in, data_ready);
        end
        p_interrupt = 3'b011;
        local_write(6'h04, 32'h2, 2'b10);
        checks++;
        if (user_interrupt !== 1'b0) begin
            errors++; $display("FAIL irq_latency got %b want 0", user_interrupt);
        end
        step();
        checks++;
        if (user_interrupt !== 1'b1) begin
            errors++; $display("FAIL irq_on got %b want 1", user_interrupt);
        end
        local_write(6'h04, 32'hFFFF_FF04, 2'b00);
        step();
        checks++;
        if (user_interrupt !== 1'b0) begin
            errors++; $display("FAIL irq_off got %b want 0", user_interrupt);
        end
        local_read(6'h04, rdy, d);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("FAIL mask_read got %h want 00000004", d);
        end
        local_read(6'h00, rdy, d);
        checks++;
        if (d !== 32'h30) begin
            errors++; $display("FAIL status_irq got %h want 00000030", d);
        end
        local_read(6'h08, rdy, d);
        checks++;
        if (d !== 32'h0 || rdy !== 1'b1) begin
            errors++; $display("FAIL local_other got rdy=%b val=%h want 1 0", rdy, d);
        end
    endtask

    task automatic test_unmapped();
        b_p_interrupt = 2'b11;
        b_address = {2'd3, 6'h00}; b_data_read_n = 2'b10;
        step();
        checks++;
        if (b_data_ready !== 1'b1 || b_data_out !== 32'h30) begin
            errors++; $display("FAIL b_status got rdy=%b out=%h want 1 00000030", b_data_ready, b_data_out);
        end
        b_data_read_n = 2'b11;
        step();
        b_address = {2'd2, 6'h00}; b_data_read_n = 2'b10;
        step();
        checks++;
        if (b_data_ready !== 1'b1 || b_data_out !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got rdy=%b out=%h want 1 0", b_data_ready, b_data_out);
        end
        checks++;
        if (b_p_data_read_n !== 4'hF || b_p_data_write_n !== 4'hF) begin
            errors++; $display("FAIL unmapped_strobe got rd=%b wr=%b want 1111 1111", b_p_data_read_n, b_p_data_write_n);
        end
        b_data_read_n = 2'b11;
        step();
    endtask

    task automatic test_back_to_back();
        p_data_ready = 3'b001; p_data_out[31:0] = 32'hCAFE_F00D;
        address = {2'd0, 6'h0C}; data_in = 32'h1122_3344;
        data_write_n = 2'b10; data_read_n = 2'b10;
        step();
        data_write_n = 2'b11;
        checks++;
        if (p_data_write_n !== 6'b111110 || p_data_read_n !== 6'h3F) begin
            errors++; $display("FAIL sim_write got wr=%b rd=%b want 111110 111111", p_data_write_n, p_data_read_n);
        end
        step();
        checks++;
        if (p_data_write_n !== 6'h3F || p_data_read_n !== 6'h3F || data_ready !== 1'b0) begin
            errors++; $display("FAIL sim_idle got wr=%b rd=%b rdy=%b want 111111 111111 0", p_data_write_n, p_data_read_n, data_ready);
        end
        step();
        checks++;
        if (p_data_read_n !== 6'b111110) begin
            errors++; $display("FAIL sim_read got rd=%b want 111110", p_data_read_n);
        end
        step();
        checks++;
        if (data_ready !== 1'b1 || data_out !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL sim_data got rdy=%b out=%h want 1 cafef00d", data_ready, data_out);
        end
        data_read_n = 2'b11; p_data_ready = 3'b000;
        step();
    endtask

    task automatic test_reset_mid_read();
        logic        seen = 1'b0;
        logic        rdy;
        logic [31:0] d;
        p_interrupt = 3'b000;
        address = {2'd2, 6'h00}; data_read_n = 2'b10;
        repeat (16) step();
        data_read_n = 2'b11;
        step();
        data_read_n = 2'b10;
        step();
        checks++;
        if (p_data_read_n !== 6'b101111) begin
            errors++; $display("FAIL rst_pre got rd=%b want 101111", p_data_read_n);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; data_read_n = 2'b11;
        checks++;
        if (p_data_read_n !== 6'h3F || p_data_write_n !== 6'h3F || data_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid got rd=%b wr=%b rdy=%b want 111111 111111 0", p_data_read_n, p_data_write_n, data_ready);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            if (data_ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_no_ready got ready_seen=1 want 0");
        end
        local_read(6'h00, rdy, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL rst_status got %h want 0", d);
        end
        local_read(6'h04, rdy, d);
        checks++;
        if (d !== 32'h0 || user_interrupt !== 1'b0) begin
            errors++; $display("FAIL rst_mask got %h irq=%b want 0 0", d, user_interrupt);
        end
    endtask

    initial begin
        rst = 1'b1;
        address = 8'h00; data_in = 32'h0; data_write_n = 2'b11; data_read_n = 2'b11;
        p_data_out = '0; p_data_ready = 3'b000; p_interrupt = 3'b000;
        b_address = 8'h00; b_data_write_n = 2'b11; b_data_read_n = 2'b11; b_p_interrupt = 2'b00;
        step();
        test_reset();
        test_zero_wait_read();
        test_wait_read();
        test_timeout();
        test_writes_irq();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tqvp_bus_sequencer.md
# tqvp_bus_sequencer

Sequences TinyQV core data accesses onto up to three peripheral slots and a local register slot. It registers each core request and issues it to the selected peripheral. For reads, it waits for the peripheral's `data_ready` under a bounded timeout, captures the result and returns it to the core with a one-cycle `data_ready` pulse. It also masks and merges the slots' user interrupts into one request line.

## Interface
Parameters:
- `NUM_PERIPH`, default 3: number of external peripheral slots, legal range 1..3. Slot 3 is always the local register slot.
- `TIMEOUT`, default 15: maximum number of READ_WAIT cycles before a read is aborted, legal range 1..255.

Ports:
- `clk` input 1: single clock for the block.
- `rst` input 1: synchronous, active-high reset.
- `address` input 8: core address. `[7:6]` selects the slot; `[5:0]` is the offset within the slot.
- `data_in` input 32: core write data.
- `data_write_n` input 2: core write request. 11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit. A write is asserted for exactly one cycle.
- `data_read_n` input 2: core read request, same encoding. It is held until the core sees `data_ready`.
- `data_out` output 32: read data, valid while `data_ready` = 1.
- `data_ready` output 1: one-cycle read-completion pulse.
- `p_address` output 6: latched offset, shared by all slots.
- `p_data_in` output 32: latched write data, shared by all slots.
- `p_data_write_n` output 2*NUM_PERIPH: per-slot write strobe. Slot i uses bits `[2i+1:2i]`.
- `p_data_read_n` output 2*NUM_PERIPH: per-slot read strobe.
- `p_data_out` input 32*NUM_PERIPH: per-slot read data.
- `p_data_ready` input NUM_PERIPH: per-slot read ready.
- `p_interrupt` input NUM_PERIPH: per-slot interrupt.
- `user_interrupt` output 1: masked OR of the slot interrupts.

## Operation
The FSM has four states: IDLE, WRITE, READ_WAIT and DONE.

- **IDLE**
  - If `data_write_n` != 11, latch the slot, offset, data and size, then go to WRITE. A write has priority if a read is asserted in the same cycle.
  - Otherwise, if `data_read_n` != 11, latch the slot, offset and size.
    - External slot (< NUM_PERIPH): go to READ_WAIT with the wait counter at 0.
    - Local slot or unmapped slot: load the read data register (0 for unmapped slots), then go to DONE.
- **WRITE**
  - External slot: drive the latched size on that slot's `p_data_write_n` for exactly this cycle.
  - Local slot: update the local register.
  - Unmapped slot: drop the write.
  - Then go to IDLE.
- **READ_WAIT**
  - Drive the latched size on the selected slot's `p_data_read_n` and increment the wait counter.
  - If that slot's `p_data_ready` = 1: capture its `p_data_out` and go to DONE.
  - Else, if the counter equals TIMEOUT: capture 32'hFFFF_FFFF, set `STATUS.err` = 1 and `STATUS.err_slot` = slot, and go to DONE.
- **DONE**
  - `data_ready` = 1 and `data_out` = the captured data; all peripheral strobes are 11.
  - Go to IDLE. The core's request is still visible in this cycle and is ignored.

Local registers (slot 3):
- Offset 0x00, STATUS
  - `[0]` err: sticky; writing 1 to bit 0 clears it.
  - `[2:1]` err_slot.
  - `[3]` busy: always reads 0 from the core.
  - `[7:4]` raw `p_interrupt` (zero-padded).
- Offset 0x04, IRQ_MASK: bits `[NUM_PERIPH-1:0]`, read/write.
- All other offsets read 0 and ignore writes.
- Byte writes update bits `[7:0]` only. For these two 8-bit registers, 16-bit and 32-bit writes behave identically.

Interrupt and idle outputs:
- `user_interrupt` = registered `|(p_interrupt & IRQ_MASK)`, which adds 1 cycle of latency.
- Non-selected slots' strobes are always 11.
- `p_address` and `p_data_in` hold their last latched values.

Reset:
- `rst` = 1 forces IDLE in the next cycle, even mid-transaction.
- All strobes = 11; `data_ready` = 0; `data_out` = 0.
- STATUS = 0; IRQ_MASK = 0; `user_interrupt` = 0.
- `p_address` = 0; `p_data_in` = 0.
- A request in flight at reset is abandoned with no `data_ready`.

## Timing
- **Read latency**, with the request first seen in IDLE at cycle 0:
  - READ_WAIT starts at cycle 1.
  - If the peripheral's ready rises in wait cycle k (k ≥ 1), the core sees `data_ready` at cycle k+1.
  - A zero-wait peripheral therefore completes in 2 cycles.
  - Local and unmapped reads: `data_ready` at cycle 1.
- **Timeout**: a read that gets no ready has `data_ready` at cycle TIMEOUT+1.
- **Write**: the peripheral strobe appears exactly at cycle 1, for 1 cycle. No `data_ready` is produced for writes.
- **Throughput**: at most one transaction in flight. A new request is accepted only in IDLE.
- **All outputs are registered.** `data_out` changes only on entry to DONE or on reset.

## Test plan
- **Zero-wait read:** slot 0 returns ready=1 with `p_data_out` = 0x12345678 → `p_data_read_n[1:0]` = 10 for 1 cycle; `data_ready` = 1 and `data_out` = 0x12345678 at cycle 2; all strobes 11 afterwards.
- **Wait-state read:** slot 1 raises ready in the 3rd READ_WAIT cycle with 0xA5A5_0001 → `data_ready` at cycle 4; `p_address` = latched offset 0x04 throughout; slots 0/2 strobes stay 11.
- **Timeout:** slot 2 never ready, TIMEOUT=15 → `data_out` = 0xFFFFFFFF at cycle 16; STATUS read = 0x05; write 0x01 to STATUS → STATUS reads 0x00.
- **Writes and interrupt mask:**
  - 8-bit write 0x3C to slot 0 offset 0x08 → `p_data_write_n[1:0]` = 00 for exactly 1 cycle; `p_data_in[7:0]` = 0x3C.
  - Write IRQ_MASK = 0x2 with `p_interrupt` = 0b011 → `user_interrupt` = 1 one cycle later; set mask to 0x4 → `user_interrupt` = 0.
- **Unmapped read and simultaneous requests:** with NUM_PERIPH=2, a read of slot 2 → `data_out` = 0 at cycle 1, with no strobe. Write and read asserted together → the write is issued; the read is accepted only if it is still asserted when the FSM is back in IDLE.
- **Reset mid-read:** assert `rst` in READ_WAIT → next cycle IDLE; all strobes 11; no `data_ready`; IRQ_MASK and STATUS are 0.
